// File: rtl/barcode_pkg.sv
// barcode_pkg
//   Shared types and constants for the station-ID barcode receiver.
//   bc_state_t  : receiver FSM states
//   TMR_W_DEF   : default pulse/sample timer width
//   ID_W        : station ID width
//   ID_TAG_MASK : ID bits that must be zero for a frame to be accepted
package barcode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SAMP,
        DONE
    } bc_state_t;

    localparam int unsigned TMR_W_DEF   = 22;
    localparam int unsigned ID_W        = 8;
    localparam logic [7:0]  ID_TAG_MASK = 8'hC0;

    // A received byte is a station ID only when its tag bits are clear.
    function automatic logic id_tag_ok(input logic [ID_W-1:0] v);
        return (v & ID_TAG_MASK) == '0;
    endfunction

endpackage

// File: rtl/barcode_rx_bc_sync.sv
// bc_sync
//   Three-flop synchronizer for the raw barcode line with falling-edge pulse.
//   Flops reset to 1 so an idle-high line never produces a false fall.
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   bc_in   in  raw asynchronous barcode line
//   bc_sync out synchronized line (second flop)
//   fall    out one-clock pulse when bc_sync goes high -> low
module bc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bc_in,
    output logic bc_sync,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], bc_in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the synchronized line, sync_q[2] its previous value.
    assign bc_sync = sync_q[1];
    assign fall    = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/barcode_rx.sv
// barcode_rx
//   Station-ID barcode receiver. Measures the start-bit low time, then samples
//   each data cell that many clocks after its falling edge, MSB first. A frame
//   whose tag bits are clear updates ID and sets the sticky ID_vld.
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   BC         in   raw barcode line, idles high
//   clr_ID_vld in   pulse, clears ID_vld (a same-clock capture wins)
//   ID         out  last accepted station ID
//   ID_vld     out  sticky valid for ID
//   busy       out  frame in progress
module barcode_rx
    import barcode_pkg::*;
#(
    parameter int unsigned TMR_W    = TMR_W_DEF,
    parameter int unsigned TMO_CLKS = (1 << TMR_W_DEF) - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            ID_vld,
    output logic            busy
);

    localparam logic [TMR_W-1:0] TMO     = TMR_W'(TMO_CLKS);
    localparam logic [TMR_W-1:0] TMR_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    logic bc_s;
    logic fall;

    bc_state_t       state_q,   state_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [TMR_W-1:0] half_q,   half_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0] shift_q,   shift_d;
    logic [ID_W-1:0] id_q,      id_d;
    logic            id_vld_q,  id_vld_d;

    bc_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .bc_in   (BC),
        .bc_sync (bc_s),
        .fall    (fall)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        half_d    = half_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        id_d      = id_q;
        id_vld_d  = id_vld_q & ~clr_ID_vld;

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end

            START: begin
                if (bc_s) begin
                    // Line released: timer holds the start-bit low time.
                    // A zero count is a sub-clock glitch, not a frame.
                    half_d  = timer_q;
                    timer_d = '0;
                    state_d = (timer_q == '0) ? IDLE : WAIT;
                end else if (timer_q == TMR_MAX) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            WAIT: begin
                if (fall) begin
                    timer_d = '0;
                    state_d = SAMP;
                end else if (timer_q == TMO) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            SAMP: begin
                // Falls seen here are ignored; only the sample point matters.
                if (timer_q == half_q) begin
                    shift_d   = {shift_q[ID_W-2:0], bc_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    timer_d   = '0;
                    state_d   = (bit_cnt_q == 3'd7) ? DONE : WAIT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            DONE: begin
                if (id_tag_ok(shift_q)) begin
                    id_d     = shift_q;
                    id_vld_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            half_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            half_q    <= half_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
        end
    end

    assign ID     = id_q;
    assign ID_vld = id_vld_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_barcode_rx.sv
module tb_barcode_rx;
    import barcode_pkg::*;

    localparam int P   = 64;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       BC;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    barcode_rx #(.TMR_W(22), .TMO_CLKS(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic       clr;
        logic [7:0] exp_id;
        logic       exp_vld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame; inputs change at posedge+1. rst_cell >= 0 injects a
    // 2-clock reset 4 clocks into that cell's low time. chk_busy checks the
    // busy latency on the start cell.
    task automatic send_frame(input logic [7:0] v, input int rst_cell, input bit chk_busy);
        int lowc;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) lowc = P / 2;
            else        lowc = v[8-c] ? (P / 4) : (3 * P / 4);
            for (int t = 0; t < P; t++) begin
                if (chk_busy && c == 0 && t == 1) chk("busy_early", busy, 0);
                if (chk_busy && c == 0 && t == 3) chk("busy_rise", busy, 1);
                if (c == rst_cell && t == 4) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    chk("rst_id", ID, 8'h00);
                    chk("rst_vld", ID_vld, 0);
                    chk("rst_busy", busy, 0);
                end
                BC = (t < lowc) ? 1'b0 : 1'b1;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_clr();
        clr_ID_vld = 1'b1;
        @(posedge clk);
        #1;
        clr_ID_vld = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] prev_id;
        bit         ok;
        bit         found;

        vecs[0] = '{val: 8'h01, clr: 1'b0, exp_id: 8'h01, exp_vld: 1'b1};
        vecs[1] = '{val: 8'h2A, clr: 1'b1, exp_id: 8'h2A, exp_vld: 1'b1};
        vecs[2] = '{val: 8'hC5, clr: 1'b0, exp_id: 8'h2A, exp_vld: 1'b1};
        vecs[3] = '{val: 8'h80, clr: 1'b1, exp_id: 8'h2A, exp_vld: 1'b0};
        vecs[4] = '{val: 8'h3F, clr: 1'b0, exp_id: 8'h3F, exp_vld: 1'b1};
        vecs[5] = '{val: 8'h00, clr: 1'b1, exp_id: 8'h00, exp_vld: 1'b1};

        rst_n      = 1'b0;
        BC         = 1'b1;
        clr_ID_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_id", ID, 8'h00);
        chk("reset_vld", ID_vld, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        prev_id = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) begin
                pulse_clr();
                chk($sformatf("clr_vld_%0d", i), ID_vld, 0);
                chk($sformatf("clr_id_%0d", i), ID, prev_id);
            end
            send_frame(vecs[i].val, -1, i == 0);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("vec_id_%0d", i), ID, vecs[i].exp_id);
            chk($sformatf("vec_vld_%0d", i), ID_vld, vecs[i].exp_vld);
            chk($sformatf("vec_busy_%0d", i), busy, 0);
            if (i == 0) chk("half", dut.half_q, P / 2 - 1);
            prev_id = vecs[i].exp_id;
        end

        // Reset mid-frame during a data cell, then a clean frame.
        send_frame(8'h15, 5, 1'b0);
        wait_idle(3000, ok);
        chk("leftover_idle", ok, 1);
        chk("leftover_vld", ID_vld, 0);
        chk("leftover_id", ID, 8'h00);
        @(posedge clk);
        #1;
        send_frame(8'h15, -1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("after_rst_id", ID, 8'h15);
        chk("after_rst_vld", ID_vld, 1);

        // One-clock glitch: zero start width aborts at once.
        pulse_clr();
        BC = 1'b0;
        @(posedge clk);
        #1;
        BC = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("glitch_busy", busy, 0);
        chk("glitch_vld", ID_vld, 0);

        // Lone 3-clock pulse: WAIT times out after TMO clocks.
        BC = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        BC = 1'b1;
        repeat (992) @(posedge clk);
        #1;
        chk("tmo_still_busy", busy, 1);
        repeat (14) @(posedge clk);
        #1;
        chk("tmo_busy", busy, 0);
        chk("tmo_vld", ID_vld, 0);
        chk("tmo_id", ID, 8'h15);

        // Clear on the exact DONE clock: the capture wins.
        found = 1'b0;
        fork
            send_frame(8'h07, -1, 1'b0);
            begin
                for (int i = 0; i < 1000 && !found; i++) begin
                    @(negedge clk);
                    if (dut.state_q == DONE) begin
                        found      = 1'b1;
                        clr_ID_vld = 1'b1;
                        @(posedge clk);
                        #1;
                        clr_ID_vld = 1'b0;
                    end
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("done_seen", found, 1);
        chk("clr_done_vld", ID_vld, 1);
        chk("clr_done_id", ID, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
